// File: rtl/signed_addsub_pkg.sv
// Shared types for the sequential signed add/subtract unit.
// Holds the controller state enum and its encodings.
package signed_addsub_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAG  = 3'd1,
    S_CMP  = 3'd2,
    S_EXEC = 3'd3,
    S_PACK = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/sm_conv.sv
// Combinational two's-complement <-> sign-magnitude converter.
// to_sm=1: din is a sign-extended operand, dout its magnitude; to_sm=0: din is a magnitude, dout its low WIDTH two's-complement bits.
module sm_conv #(
  parameter int WIDTH = 8
) (
  input  logic             to_sm,
  input  logic             sign_in,
  input  logic [WIDTH:0]   din,
  output logic [WIDTH-1:0] dout
);

  logic neg;

  // Only the low WIDTH bits of the negation are ever needed, so the top bit only steers.
  assign neg  = to_sm ? din[WIDTH] : sign_in;
  assign dout = neg ? (~din[WIDTH-1:0] + WIDTH'(1)) : din[WIDTH-1:0];

endmodule

// File: rtl/signed_addsub_seq.sv
// Multi-cycle signed add/subtract through sign-magnitude arithmetic.
// Define SIGNED_ADDSUB_SAT_EN to saturate on overflow; otherwise the result wraps.
module signed_addsub_seq
  import signed_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             zero,
  output state_t           state_dbg
);

  // Handshake: start is accepted only in the cycle busy=0; done is a one-cycle
  // pulse marking result/ovf/zero valid, and those stay held until the next done.

  localparam logic [WIDTH:0] HALF    = {2'b01, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0] HALF_M1 = {2'b00, {(WIDTH-1){1'b1}}};
`ifdef SIGNED_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t state, next_state;

  logic [WIDTH-1:0] a_r, b_r;
  logic             op_r;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             a_ge, same_sgn;
  logic [WIDTH:0]   mag_r;
  logic             sgn_r;

  logic [WIDTH-1:0] mag_a_c, mag_b_c, tc_lo;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_MAG;
      S_MAG:   next_state = S_CMP;
      S_CMP:   next_state = S_EXEC;
      S_EXEC:  next_state = S_PACK;
      S_PACK:  next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state != S_IDLE);
      done <= (next_state == S_DONE);
    end
  end

  assign state_dbg = state;

  sm_conv #(.WIDTH(WIDTH)) u_conv_a (
    .to_sm   (1'b1),
    .sign_in (1'b0),
    .din     ({a_r[WIDTH-1], a_r}),
    .dout    (mag_a_c)
  );

  sm_conv #(.WIDTH(WIDTH)) u_conv_b (
    .to_sm   (1'b1),
    .sign_in (1'b0),
    .din     ({b_r[WIDTH-1], b_r}),
    .dout    (mag_b_c)
  );

  sm_conv #(.WIDTH(WIDTH)) u_conv_r (
    .to_sm   (1'b0),
    .sign_in (sgn_r),
    .din     (mag_r),
    .dout    (tc_lo)
  );

  // Overflow is judged on the exact magnitude, so it is the same in both builds.
  always_comb begin
    ovf_c = sgn_r ? (mag_r > HALF) : (mag_r > HALF_M1);
    res_c = tc_lo;
`ifdef SIGNED_ADDSUB_SAT_EN
    if (ovf_c) res_c = sgn_r ? MIN_NEG : MAX_POS;
`endif
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 1'b0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      a_ge     <= 1'b0;
      same_sgn <= 1'b0;
      mag_r    <= '0;
      sgn_r    <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
          end
        end
        S_MAG: begin
          sgn_a <= a_r[WIDTH-1];
          sgn_b <= b_r[WIDTH-1] ^ op_r;
          mag_a <= mag_a_c;
          mag_b <= mag_b_c;
        end
        S_CMP: begin
          a_ge     <= (mag_a >= mag_b);
          same_sgn <= (sgn_a == sgn_b);
        end
        S_EXEC: begin
          if (same_sgn) begin
            mag_r <= {1'b0, mag_a} + {1'b0, mag_b};
            sgn_r <= sgn_a;
          end else if (a_ge) begin
            mag_r <= {1'b0, mag_a - mag_b};
            // Cancelling magnitudes must come out as +0.
            sgn_r <= (mag_a == mag_b) ? 1'b0 : sgn_a;
          end else begin
            mag_r <= {1'b0, mag_b - mag_a};
            sgn_r <= sgn_b;
          end
        end
        S_PACK: begin
          result <= res_c;
          ovf    <= ovf_c;
          zero   <= (res_c == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_addsub_seq.sv
// Scoreboard bench for signed_addsub_seq at WIDTH=8 with hand-computed vectors.
// Expected results follow SIGNED_ADDSUB_SAT_EN when the bench is built with it.
module tb_signed_addsub_seq;
  import signed_addsub_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [31:0]  cyc;
    logic         ovf;
    logic         zero;
    logic [W-1:0] res;
  } exp_t;

  logic         clk;
  logic         RESET;
  logic         start;
  logic         op;
  logic [W-1:0] a, b;
  logic         busy, done, ovf, zero;
  logic [W-1:0] result;
  state_t       state_dbg;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  signed_addsub_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf),
    .zero      (zero),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver tasks: called and returning at a falling edge
  task automatic wait_idle();
    int g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (busy) begin
      n_errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, expected 0", busy, g);
    end
  endtask

  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                          input logic [W-1:0] er, input logic eo);
    exp_t e;
    wait_idle();
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    op    = top;
    e.cyc  = 32'(cyc + 5);
    e.ovf  = eo;
    e.zero = (er == '0);
    e.res  = er;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom_range(0, 255));
    b     = W'($urandom_range(0, 255));
    op    = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), e.cyc);
        chk("result", 32'(result), 32'(e.res));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("zero", 32'(zero), 32'(e.zero));
      end
    end
  end

  // vector table: a, b, op, wrap result, saturated result, ovf
  logic [W-1:0] va[13], vb[13], vw[13], vs[13];
  logic         vop[13], vo[13];

  initial begin
    va  = '{8'd5, 8'd100, 8'h80, 8'd7, 8'h80, 8'(-50), 8'd20, 8'(-100), 8'd127, 8'hFF, 8'd127, 8'h80, 8'd0};
    vb  = '{8'd3, 8'd100, 8'd1,  8'd7, 8'h80, 8'd20,   8'd50, 8'(-100), 8'hFF,  8'(-127), 8'd0, 8'h80, 8'd0};
    vop = '{1'b0, 1'b0,   1'b1,  1'b1, 1'b1,  1'b0,    1'b1,  1'b0,     1'b1,   1'b0,  1'b0,   1'b0,  1'b1};
    vw  = '{8'd8, 8'(-56), 8'd127, 8'd0, 8'd0, 8'(-30), 8'(-30), 8'd56,  8'h80, 8'h80, 8'd127, 8'd0,  8'd0};
    vs  = '{8'd8, 8'd127,  8'h80,  8'd0, 8'd0, 8'(-30), 8'(-30), 8'h80,  8'd127, 8'h80, 8'd127, 8'h80, 8'd0};
    vo  = '{1'b0, 1'b1,    1'b1,   1'b0, 1'b0, 1'b0,    1'b0,    1'b1,   1'b1,  1'b0,  1'b0,   1'b1,  1'b0};

    RESET = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_ovf", 32'(ovf), 0);
    chk("reset_zero", 32'(zero), 0);
    chk("reset_state", 32'(state_dbg), 32'(S_IDLE));
    RESET = 1'b0;

    // directed vectors; the first start lands on the first edge after reset release
    for (int i = 0; i < 13; i++) begin
`ifdef SIGNED_ADDSUB_SAT_EN
      drive_op(va[i], vb[i], vop[i], vs[i], vo[i]);
`else
      drive_op(va[i], vb[i], vop[i], vw[i], vo[i]);
`endif
    end

    // second start while busy must be ignored
    drive_op(8'd9, 8'd4, 1'b0, 8'd13, 1'b0);
    chk("busy_after_start", 32'(busy), 1);
    start = 1'b1;
    a     = 8'd50;
    b     = 8'd60;
    op    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);

    // start held high: back-to-back operations six cycles apart
    wait_idle();
    begin
      exp_t e;
      start = 1'b1;
      a     = 8'd10;
      b     = 8'd3;
      op    = 1'b1;
      e.ovf  = 1'b0;
      e.zero = 1'b0;
      e.res  = 8'd7;
      e.cyc  = 32'(cyc + 5);
      exp_q.push_back(e);
      e.cyc  = 32'(cyc + 11);
      exp_q.push_back(e);
      repeat (7) @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
    end

    // reset while in EXEC: outputs clear at once, no done for the aborted op
    wait_idle();
    start = 1'b1;
    a     = 8'd33;
    b     = 8'd44;
    op    = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_state_exec", 32'(state_dbg), 32'(S_EXEC));
    #2;
    RESET = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_ovf", 32'(ovf), 0);
    chk("abort_zero", 32'(zero), 0);
    @(negedge clk);
    RESET = 1'b0;
    drive_op(8'(-3), 8'd5, 1'b1, 8'(-8), 1'b0);

    // drain the scoreboard, then idle to expose any stray done
    begin
      int g = 0;
      while (exp_q.size() != 0 && g < 100) begin
        @(negedge clk);
        g++;
      end
    end
    chk("queue_drained", 32'(exp_q.size()), 0);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
